// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, pixel layout and colour-bar table for the scan controller.
package vga_pkg;

  localparam int DEF_H_VIS  = 640;
  localparam int DEF_H_FP   = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP   = 48;
  localparam int DEF_V_VIS  = 480;
  localparam int DEF_V_FP   = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP   = 33;

  localparam int DEF_H_TOTAL = DEF_H_VIS + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL = DEF_V_VIS + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  // Pixel word is {B[3:0], G[3:0], R[3:0]}
  typedef logic [11:0] pixel_t;
  localparam int PIX_R = 0;
  localparam int PIX_G = 4;
  localparam int PIX_B = 8;

  localparam int BAR_W = 80;
  localparam pixel_t BAR_COLOURS [0:7] = '{
    12'hfff, 12'hff0, 12'hf0f, 12'hf00, 12'h0ff, 12'h0f0, 12'h00f, 12'h000
  };

  function automatic pixel_t bar_colour(input logic [9:0] h);
    logic [9:0] idx;
    idx = h / 10'(BAR_W);
    return (idx < 10'd8) ? BAR_COLOURS[idx[2:0]] : 12'h000;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with asynchronous active-low reset to a per-bit value.
module vga_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/vga_scan_ctrl.sv
// VGA raster generator and pixel sink aligned to the page pipeline latency.
// Optional build macro VGA_TEST_PATTERN_EN adds test_en and an eight-bar colour pattern.
module vga_scan_ctrl
  import vga_pkg::*;
#(
  parameter int H_VIS   = DEF_H_VIS,
  parameter int H_FP    = DEF_H_FP,
  parameter int H_SYNC  = DEF_H_SYNC,
  parameter int H_BP    = DEF_H_BP,
  parameter int V_VIS   = DEF_V_VIS,
  parameter int V_FP    = DEF_V_FP,
  parameter int V_SYNC  = DEF_V_SYNC,
  parameter int V_BP    = DEF_V_BP,
  parameter int PIX_LAT = 1
) (
  input  logic        vga_clk,
  input  logic        vga_rst_n,
  output logic [9:0]  x_pos,
  output logic [9:0]  y_pos,
  input  pixel_t      pixel_data,
`ifdef VGA_TEST_PATTERN_EN
  input  logic        test_en,
`endif
  output logic        vblank_tick,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [9:0]  H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_START = 10'(V_VIS);
  // 11-bit bounds so a 1024-wide total cannot alias the sync end to zero
  localparam logic [10:0] H_VIS_E = 11'(H_VIS);
  localparam logic [10:0] HS_BEG  = 11'(H_VIS + H_FP);
  localparam logic [10:0] HS_END  = 11'(H_VIS + H_FP + H_SYNC);
  localparam logic [10:0] V_VIS_E = 11'(V_VIS);
  localparam logic [10:0] VS_BEG  = 11'(V_VIS + V_FP);
  localparam logic [10:0] VS_END  = 11'(V_VIS + V_FP + V_SYNC);

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_chk
    $error("vga_scan_ctrl: H_TOTAL and V_TOTAL must not exceed 1024");
  end
  if (PIX_LAT < 1 || PIX_LAT > 4) begin : g_lat_chk
    $error("vga_scan_ctrl: PIX_LAT must be in 1..4");
  end

  logic [9:0] h_cnt, v_cnt;

  always_ff @(posedge vga_clk or negedge vga_rst_n) begin
    if (!vga_rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  assign x_pos = h_cnt;
  assign y_pos = v_cnt;

  // Stage 0: raster decode straight from the counters
  logic video_on, hs_n, vs_n;
  logic [10:0] h_ext, v_ext;

  always_comb begin
    h_ext    = {1'b0, h_cnt};
    v_ext    = {1'b0, v_cnt};
    video_on = (h_ext < H_VIS_E) && (v_ext < V_VIS_E);
    hs_n     = !((h_ext >= HS_BEG) && (h_ext < HS_END));
    vs_n     = !((v_ext >= VS_BEG) && (v_ext < VS_END));
  end

  // Stages 1..PIX_LAT: hold control back until the page's pixel arrives
  logic video_on_d, hs_n_d, vs_n_d;

  vga_delay_line #(
    .WIDTH   (3),
    .DEPTH   (PIX_LAT),
    .RST_VAL (3'b011)
  ) u_ctrl_dly (
    .clk   (vga_clk),
    .rst_n (vga_rst_n),
    .d     ({video_on, hs_n, vs_n}),
    .q     ({video_on_d, hs_n_d, vs_n_d})
  );

  pixel_t pix_sel;

`ifdef VGA_TEST_PATTERN_EN
  logic [9:0] h_cnt_d;

  vga_delay_line #(
    .WIDTH   (10),
    .DEPTH   (PIX_LAT),
    .RST_VAL (10'd0)
  ) u_hpos_dly (
    .clk   (vga_clk),
    .rst_n (vga_rst_n),
    .d     (h_cnt),
    .q     (h_cnt_d)
  );

  always_comb begin
    pix_sel = pixel_data;
    if (test_en) pix_sel = bar_colour(h_cnt_d);
  end
`else
  always_comb begin
    pix_sel = pixel_data;
  end
`endif

  // Output stage: pins register; blanking forces black regardless of page colour
  always_ff @(posedge vga_clk or negedge vga_rst_n) begin
    if (!vga_rst_n) begin
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vblank_tick <= 1'b0;
    end else begin
      vga_hs      <= hs_n_d;
      vga_vs      <= vs_n_d;
      vblank_tick <= (h_cnt == 10'd0) && (v_cnt == V_START);
      if (video_on_d) begin
        vga_r <= pix_sel[PIX_R +: 4];
        vga_g <= pix_sel[PIX_G +: 4];
        vga_b <= pix_sel[PIX_B +: 4];
      end else begin
        vga_r <= '0;
        vga_g <= '0;
        vga_b <= '0;
      end
    end
  end

endmodule

// File: doc/vga_scan_ctrl.md
Name: vga_scan_ctrl

Overview:
- VGA raster timing generator and pixel sink at the other end of the page-renderer interface.
- Produces the x_pos/y_pos scan coordinates that page modules consume, and takes back their registered 12-bit pixel_data.
- Aligns sync and blanking to the page pipeline latency and drives the board VGA pins.
- Default mode is 640x480@60 on a 25 MHz vga_clk.

Parameters:
H_VIS, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync pulse width
H_BP, 48, horizontal back porch
V_VIS, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width
V_BP, 33, vertical back porch
PIX_LAT, 1, page pipeline latency in clocks from x_pos/y_pos to pixel_data (legal 1..4)

Ports:
vga_clk  in  1  pixel clock
vga_rst_n  in  1  asynchronous, active-low reset
x_pos  out  10  horizontal counter h_cnt, 0..H_TOTAL-1
y_pos  out  10  vertical counter v_cnt, 0..V_TOTAL-1
pixel_data  in  12  page colour {B[3:0],G[3:0],R[3:0]}, valid PIX_LAT clocks after coordinates
vblank_tick  out  1  one-clock pulse at the start of vertical blanking
vga_r  out  4  red pin
vga_g  out  4  green pin
vga_b  out  4  blue pin
vga_hs  out  1  hsync, active low
vga_vs  out  1  vsync, active low

Behaviour:
- Totals: H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_VIS+V_FP+V_SYNC+V_BP (525). Both must be ≤1024, checked by elaboration assertion.
- Reset is asynchronous on vga_rst_n low:
  - h_cnt = v_cnt = 0.
  - Delay-line stages cleared to inactive (hs=1, vs=1, video_on=0).
  - vga_r/g/b = 0, vga_hs = vga_vs = 1, vblank_tick = 0.
- Counting:
  - h_cnt increments each clock and wraps H_TOTAL-1 → 0.
  - On that wrap, v_cnt increments and wraps V_TOTAL-1 → 0.
  - Both are 10-bit registered; x_pos/y_pos expose them directly, including blanking values. Page modules must tolerate out-of-range coordinates.
- Stage-0 combinational decode, from the counters:
  - video_on = (h_cnt < H_VIS) && (v_cnt < V_VIS).
  - hs_n low when H_VIS+H_FP ≤ h_cnt < H_VIS+H_FP+H_SYNC (656..751).
  - vs_n low when V_VIS+V_FP ≤ v_cnt < V_VIS+V_FP+V_SYNC (490..491).
- Alignment: video_on, hs_n and vs_n pass through a PIX_LAT-stage shift register. The output register then captures:
  - vga_r ← pixel_data[3:0], vga_g ← pixel_data[7:4], vga_b ← pixel_data[11:8] when the delayed video_on = 1; otherwise all 0.
  - vga_hs/vga_vs ← delayed hs_n/vs_n.
- Latency: coordinate to pins is PIX_LAT+1 clocks; sync and colour are always mutually aligned.
- vblank_tick is a registered pulse. It is high the clock after h_cnt=0, v_cnt=V_VIS (counter time), i.e. exactly once per frame (every 420000 clocks). It is not delayed.
- No pixel_data is sampled while video_on is low. Blanking is forced black even if the page outputs white.
- Reset deassertion mid-frame restarts at (0,0). The first frame after reset is full length, and its first vblank_tick occurs 384000 clocks after release.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- Defined: adds input test_en (1 bit). When test_en=1, pixel_data is ignored and eight 80-pixel-wide vertical colour bars are generated from the delayed h_cnt.
  - Bar order: fff, ff0(BG), f0f, f00, 0ff, 0f0, 00f, 000, in {B,G,R} encoding.
  - Timing and latency are unchanged.
- Undefined: no test_en port, no bar logic; pixel_data path only.

Decomposition:
- Package vga_pkg holds:
  - default timing constants (H_VIS..V_BP, H_TOTAL, V_TOTAL);
  - the 12-bit pixel typedef with field offsets R=0, G=4, B=8;
  - the colour-bar lookup constants.
- Sub-module vga_delay_line: parameterised-depth, async-active-low-reset shift register with a per-bit reset value. Used for the {video_on, hs_n, vs_n} alignment.

Test Plan:
1. Hold vga_rst_n low 5 clocks → x_pos=0, y_pos=0, vga_hs=1, vga_vs=1, RGB=0, vblank_tick=0.
2. Run 2 lines with PIX_LAT=1 → vga_hs low for exactly 96 clocks, first low at pins 2 clocks after x_pos=656. x_pos wraps 799→0 and y_pos steps 0→1 on the same edge.
3. Drive pixel_data=12'h2cf constant → during visible region vga_r=f, vga_g=c, vga_b=2. At x_pos=700 (delayed), RGB=0.
4. Run two full frames → y_pos wraps 524→0 after x_pos=799. vga_vs low for exactly 1600 clocks per frame. vblank_tick pulses are 420000 clocks apart.
5. Assert vga_rst_n low asynchronously at x_pos=300, y_pos=200 → outputs hit reset values without a clock edge. After release, counting restarts at (0,0).
6. With VGA_TEST_PATTERN_EN and test_en=1 → pixel at delayed h_cnt=85 on a visible line is ff0 (B=f,G=f,R=0), and pixel_data changes have no effect.
